// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing a 16-bit combinational boot ROM between the CPU (port 0)
// and the boot copier (port 1); assembles 16/32-bit reads and flags out-of-range words.
module rom_fetch_arbiter #(
  parameter logic [31:0] ROM_WORDS = 32'h1D3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        size0,
  input  logic        size1,
  output logic [31:0] data0,
  output logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rom_addr,
  output logic        rom_rd,
  input  logic [15:0] rom_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD_FIRST, RD_SECOND, DONE} state_t;

  state_t      st, st_nxt;
  logic        last_grant, gnt, size_q, err_q;
  logic [31:0] addr_q, addr_p1;
  logic [15:0] first;
  logic        win, oor_first, oor_second;
  logic        res_load, res_err;
  logic [31:0] res_data;

  assign addr_p1    = addr_q + 32'd1;
  assign oor_first  = addr_q >= ROM_WORDS;
  // The wrapped address 0 would look in range, so the wrap is flagged explicitly.
  assign oor_second = (addr_p1 >= ROM_WORDS) || (addr_q == 32'hFFFF_FFFF);
  assign win        = (req0 && req1) ? ~last_grant : req1;

  assign busy = (st != IDLE);
  assign ack0 = (st == DONE) && !gnt;
  assign ack1 = (st == DONE) && gnt;

  always_comb begin
    st_nxt   = st;
    rom_rd   = 1'b0;
    rom_addr = 32'd0;
    res_load = 1'b0;
    res_err  = 1'b0;
    res_data = 32'd0;
    case (st)
      IDLE: if (req0 || req1) st_nxt = RD_FIRST;
      RD_FIRST: begin
        rom_rd   = 1'b1;
        rom_addr = addr_q;
        st_nxt   = size_q ? RD_SECOND : DONE;
        if (!size_q) begin
          res_load = 1'b1;
          res_err  = oor_first;
          res_data = {16'h0, oor_first ? 16'h0 : rom_data};
        end
      end
      RD_SECOND: begin
        rom_rd   = 1'b1;
        rom_addr = addr_p1;
        st_nxt   = DONE;
        res_load = 1'b1;
        res_err  = err_q || oor_second;
        res_data = {first, oor_second ? 16'h0 : rom_data};
      end
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // Results land in the port registers on the edge into DONE, so they are valid with ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      size_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      first      <= 16'h0;
      data0      <= 32'd0;
      data1      <= 32'd0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      case (st)
        IDLE: if (req0 || req1) begin
          gnt    <= win;
          addr_q <= win ? addr1 : addr0;
          size_q <= win ? size1 : size0;
        end
        RD_FIRST: begin
          first <= oor_first ? 16'h0 : rom_data;
          err_q <= oor_first;
        end
        DONE:    last_grant <= gnt;
        default: ;
      endcase
      if (res_load) begin
        if (gnt) begin
          data1 <= res_data;
          err1  <= res_err;
        end else begin
          data0 <= res_data;
          err0  <= res_err;
        end
      end
    end
  end

endmodule
